// File: rtl/pe_result_packer_if.sv
// Handshake bundle for the packer: PE-result input stream plus register-file write port.
// The master modport is the packer's view; the slave modport is the surrounding lane/register file.
interface pe_result_packer_if #(
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_data;
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_be;

   modport master (
      input  in_valid,
      input  in_data,
      input  wr_ready,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output wr_be
   );

   modport slave (
      output in_valid,
      output in_data,
      output wr_ready,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  wr_be
   );
endinterface

// File: rtl/pe_result_packer.sv
// Collects per-element PE results and packs them into 32-bit vector-register words,
// issuing one byte-enabled register-file write per word through a single pack buffer.
module pe_result_packer #(
   parameter int ADDR_W = 5,
   parameter int VL_W   = 6
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  start,
   input  logic [VL_W-1:0]       vl,
   input  logic [1:0]            vsew,
   input  logic [1:0]            widening,
   input  logic [ADDR_W-1:0]     base_addr,
   pe_result_packer_if.master    bus,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_FIN
   } state_t;

   // Destination element width code (0=8b, 1=16b, 2=32b), saturating at 32b.
   function automatic logic [1:0] calc_dew(input logic [1:0] sew, input logic [1:0] wid);
      logic [2:0] sum;
      logic [2:0] add;
      add = (wid == 2'd1) ? 3'd1 : (wid == 2'd2) ? 3'd2 : 3'd0;
      sum = {1'b0, sew} + add;
      return (sum > 3'd2) ? 2'd2 : sum[1:0];
   endfunction

   function automatic logic [31:0] elem_mask(input logic [1:0] dew);
      case (dew)
         2'd0:    return 32'h0000_00FF;
         2'd1:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [3:0] elem_be(input logic [1:0] dew);
      case (dew)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [1:0] last_slot(input logic [1:0] dew);
      case (dew)
         2'd0:    return 2'd3;
         2'd1:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   logic [1:0]        dew_q, dew_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [VL_W-1:0]   elem_cnt_q, elem_cnt_d;
   logic [1:0]        slot_q, slot_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [31:0]       buf_q, buf_d;
   logic [3:0]        be_q, be_d;

   logic [1:0]        byte_off;
   logic [31:0]       lane_data;
   logic [3:0]        lane_be;
   logic              word_full;
   logic              last_elem;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= S_IDLE;
         vl_q       <= '0;
         dew_q      <= '0;
         base_q     <= '0;
         elem_cnt_q <= '0;
         slot_q     <= '0;
         word_idx_q <= '0;
         buf_q      <= '0;
         be_q       <= '0;
      end else begin
         state_q    <= state_d;
         vl_q       <= vl_d;
         dew_q      <= dew_d;
         base_q     <= base_d;
         elem_cnt_q <= elem_cnt_d;
         slot_q     <= slot_d;
         word_idx_q <= word_idx_d;
         buf_q      <= buf_d;
         be_q       <= be_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vl_d       = vl_q;
      dew_d      = dew_q;
      base_d     = base_q;
      elem_cnt_d = elem_cnt_q;
      slot_d     = slot_q;
      word_idx_d = word_idx_q;
      buf_d      = buf_q;
      be_d       = be_q;

      // Lane position in bytes: slot scaled by the element size.
      byte_off   = slot_q << dew_q;
      lane_data  = (bus.in_data & elem_mask(dew_q)) << {byte_off, 3'b000};
      lane_be    = elem_be(dew_q) << byte_off;
      word_full  = (slot_q == last_slot(dew_q));
      last_elem  = (elem_cnt_q == (vl_q - VL_W'(1)));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               vl_d       = vl;
               dew_d      = calc_dew(vsew, widening);
               base_d     = base_addr;
               elem_cnt_d = '0;
               slot_d     = '0;
               word_idx_d = '0;
               buf_d      = '0;
               be_d       = '0;
               state_d    = (vl == '0) ? S_FIN : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bus.in_valid) begin
               buf_d      = buf_q | lane_data;
               be_d       = be_q | lane_be;
               slot_d     = slot_q + 2'd1;
               elem_cnt_d = elem_cnt_q + VL_W'(1);
               if (word_full || last_elem) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (bus.wr_ready) begin
               word_idx_d = word_idx_q + ADDR_W'(1);
               slot_d     = '0;
               buf_d      = '0;
               be_d       = '0;
               state_d    = (elem_cnt_q == vl_q) ? S_FIN : S_COLLECT;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Write-port fields read as zero except while a write is being offered.
   assign bus.in_ready = (state_q == S_COLLECT);
   assign bus.wr_en    = (state_q == S_WRITE);
   assign bus.wr_addr  = bus.wr_en ? (base_q + word_idx_q) : '0;
   assign bus.wr_data  = bus.wr_en ? buf_q : '0;
   assign bus.wr_be    = bus.wr_en ? be_q : '0;
   assign busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign done         = (state_q == S_FIN);

endmodule

// File: doc/pe_result_packer.md
Name: pe_result_packer

Overview:
- Sits at the output end of the PE lane and collects successive per-element results (32-bit PE `out`, element in the low bits).
- Packs them into 32-bit vector-register words according to the destination element width: SEW adjusted for widening.
- Issues one register-file write per packed word using a valid/ready write port with byte enables.
- Drives the PE-result stream with a valid/ready handshake and signals completion to the control unit.

Parameters:
- ADDR_W, 5, width of word address into the vector register file
- VL_W, 6, width of the vector-length (element count) input; max vl = 2**VL_W-1

Ports:
- clk  input  1  clock
- n_reset  input  1  asynchronous active-low reset
- start  input  1  1-cycle pulse: latch vl, vsew, widening, base_addr and begin collecting
- vl  input  VL_W  number of elements to collect
- vsew  input  2  source element width: 0=8b, 1=16b, 2=32b
- widening  input  2  2'd1 widening, 2'd2 quad widening, 0 none
- base_addr  input  ADDR_W  word address of first destination word
- in_valid  input  1  PE result valid
- in_ready  output  1  packer accepts in_data this cycle
- in_data  input  32  PE result; only low destination-width bits used
- wr_en  output  1  write request valid
- wr_ready  input  1  register file accepts write
- wr_addr  output  ADDR_W  destination word address
- wr_data  output  32  packed word
- wr_be  output  4  byte enables of valid lanes
- busy  output  1  high from cycle after start until done
- done  output  1  1-cycle pulse after final write handshake (or empty vl)

Behaviour:
- Reset (async, n_reset=0): state IDLE. in_ready, wr_en, wr_addr, wr_data, wr_be, busy and done are all 0. Internal counters cleared. Reset mid-operation abandons the transfer with no further writes.
- Destination width: dew = vsew + (widening==1 ? 1 : widening==2 ? 2 : 0), saturated at 2. Elements per word: epw = 4 >> dew, giving 4, 2 or 1. Element bytes = 1 << dew.
- States: IDLE, COLLECT, WRITE, FIN.
- IDLE:
  - start → latch config, clear elem_cnt/slot/word_idx, zero the pack buffer.
  - If vl==0 → FIN, else → COLLECT.
  - start while not IDLE is ignored.
- COLLECT: in_ready=1.
  - On in_valid&&in_ready, write in_data[8*bytes-1:0] into lane slot*bytes and set the matching be bits.
  - slot increments. elem_cnt increments.
  - If slot==epw-1 or elem_cnt==vl-1 → WRITE (register outputs, wr_en=1 next cycle).
- WRITE: in_ready=0, wr_en=1, wr_addr = base_addr + word_idx (mod 2**ADDR_W, wraps).
  - Unfilled lanes of wr_data are 0; wr_be covers filled lanes only.
  - Outputs are held stable until wr_ready.
  - On wr_ready: word_idx++, slot=0, buffer/be cleared. If all vl elements are consumed → FIN, else → COLLECT.
- FIN: done=1 for exactly one cycle, busy=0 the same cycle, → IDLE.
- busy=1 in COLLECT and WRITE.
- Latency: the element completing a word is accepted in cycle N; wr_en is asserted in cycle N+1. The minimum rate is one word per epw+1 cycles; no accept occurs while a write is pending (single buffer).
- in_valid without a transfer in progress (IDLE/FIN) is ignored, since in_ready=0 there.
- Partial last word: written with only the filled lanes' be set.

Test Plan:
- vsew=0, widening=0, vl=8, base=3, inputs 0x11..0x88 streamed back-to-back, wr_ready=1 → writes 0x44332211 @3 be=4'hF, then 0x88776655 @4 be=4'hF; done pulses once, busy then falls.
- vsew=0, widening=1, vl=3, inputs 0xAAAA1234, 0x5678, 0x9ABC → 0x56781234 @base be=4'hF, then 0x00009ABC @base+1 be=4'h3 (partial word, upper lanes zero).
- vsew=0, widening=2 (dew=2), vl=2, base=31, ADDR_W=5 → word 0 @31, word 1 @0 (address wrap), each be=4'hF.
- Backpressure: vsew=2, vl=2, wr_ready held 0 for 5 cycles → wr_en/wr_addr/wr_data stable, in_ready=0 throughout, second element accepted only after the handshake.
- vl=0 start → no wr_en, done pulse exactly one cycle later. Second start during busy → ignored, no config change.
- n_reset asserted mid-COLLECT after 1 of 4 bytes → all outputs 0 immediately. A new start then runs cleanly with no stale lanes or be bits.
